// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searched upward from ptr+1, with wrap.
module rr_arbiter #(
    parameter int unsigned NumReq = 4
) (
    input  logic [NumReq-1:0]         req,
    input  logic [$clog2(NumReq)-1:0] ptr,
    output logic [NumReq-1:0]         gnt,
    output logic                      any
);

    localparam int unsigned PtrW = $clog2(NumReq);

    logic [PtrW-1:0] idx;
    logic            found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NumReq; i++) begin
            idx = PtrW'((32'(ptr) + i) % NumReq);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NumReq valid/ready producers.
// A grant is held for a packet or MaxBurst words, then released through one IDLE cycle.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NumReq     = 4,
    parameter int unsigned WordLength = 8,
    parameter int unsigned MaxBurst   = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumReq-1:0]                    req_valid_i,
    input  logic [NumReq-1:0][WordLength-1:0]    req_data_i,
    input  logic [NumReq-1:0]                    req_last_i,
    output logic [NumReq-1:0]                    req_ready_o,
    output logic                                 fifo_wr_o,
    output logic [WordLength-1:0]                fifo_wdata_o,
    input  logic                                 fifo_full_i,
    output logic [NumReq-1:0]                    grant_o,
    output logic                                 busy_o
);

    localparam int unsigned PtrW  = $clog2(NumReq);
    localparam int unsigned BeatW = $clog2(MaxBurst + 1);

    arb_state_e        state_q, state_d;
    logic [NumReq-1:0] grant_q, grant_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [BeatW-1:0]  beat_q, beat_d, beat_inc;
    logic [PtrW-1:0]   g_idx;
    logic [NumReq-1:0] rr_gnt;
    logic              rr_any;
    logic              wr_c;

    rr_arbiter #(
        .NumReq (NumReq)
    ) u_rr (
        .req (req_valid_i),
        .ptr (ptr_q),
        .gnt (rr_gnt),
        .any (rr_any)
    );

    // Index of the held one-hot grant.
    always_comb begin
        g_idx = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (grant_q[PtrW'(i)]) begin
                g_idx = PtrW'(i);
            end
        end
    end

    assign beat_inc = beat_q + BeatW'(1);

    // Next state plus the combinational handshake; nothing is accepted while reset is asserted.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        beat_d       = beat_q;
        req_ready_o  = '0;
        wr_c         = 1'b0;
        fifo_wdata_o = '0;

        case (state_q)
            IDLE: begin
                if (rr_any) begin
                    grant_d = rr_gnt;
                    beat_d  = '0;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                fifo_wdata_o = req_data_i[g_idx];
                if (!rst_i) begin
                    req_ready_o[g_idx] = !fifo_full_i;
                    wr_c               = req_valid_i[g_idx] & !fifo_full_i;
                end
                if (wr_c) begin
                    beat_d = beat_inc;
                    if (req_last_i[g_idx] || (beat_inc == BeatW'(MaxBurst))) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = g_idx;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ptr resets to the last producer so producer 0 wins first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PtrW'(NumReq - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

    assign fifo_wr_o = wr_c;
    assign grant_o   = grant_q;
    assign busy_o    = (state_q == LOCK);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: producer queues, a counting FIFO model and a
// transaction-level arbitration model predict every output each cycle.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int MB = 4;
    localparam int IW = $clog2(NR);

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0][W-1:0] req_data;
    logic [NR-1:0]        req_last;
    logic [NR-1:0]        req_ready;
    logic                 fifo_wr;
    logic [W-1:0]         fifo_wdata;
    logic                 fifo_full;
    logic [NR-1:0]        grant;
    logic                 busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NumReq     (NR),
        .WordLength (W),
        .MaxBurst   (MB)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_last_i   (req_last),
        .req_ready_o  (req_ready),
        .fifo_wr_o    (fifo_wr),
        .fifo_wdata_o (fifo_wdata),
        .fifo_full_i  (fifo_full),
        .grant_o      (grant),
        .busy_o       (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;

    // Producer queues: pending words per producer, oldest first.
    bit [W-1:0] dq [NR][$];
    bit         lq [NR][$];
    bit         pres [NR];
    bit         acc  [NR];

    // Arbitration model: owner index, words taken in this grant, last released owner.
    int m_busy, m_g, m_beats, m_ptr;
    int fq_cnt, depth, p_pop, p_pres, maxlen;
    bit autogen, rst_cur, armed;
    bit [NR-1:0] mask;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_word(int n, bit [W-1:0] d, bit l);
        dq[n].push_back(d);
        lq[n].push_back(l);
    endtask

    task automatic clear_all();
        for (int n = 0; n < NR; n++) begin
            dq[n].delete();
            lq[n].delete();
            pres[n] = 1'b0;
            acc[n]  = 1'b0;
        end
        fq_cnt = 0;
    endtask

    task automatic step();
        logic [NR-1:0] eg, er;
        logic          ew;
        bit            found, do_pop;
        int            idx, len;

        @(negedge clk);
        for (int n = 0; n < NR; n++) begin
            if (acc[n]) begin
                void'(dq[n].pop_front());
                void'(lq[n].pop_front());
                pres[n] = 1'b0;
                acc[n]  = 1'b0;
            end
            if (autogen && mask[IW'(n)] && dq[n].size() == 0) begin
                len = int'($urandom_range(maxlen, 1));
                for (int k = 0; k < len; k++) push_word(n, W'($urandom), k == len - 1);
            end
            if (!pres[n] && dq[n].size() > 0 && int'($urandom_range(99, 0)) < p_pres) pres[n] = 1'b1;
            req_valid[IW'(n)] = pres[n];
            req_data[IW'(n)]  = pres[n] ? dq[n][0] : '0;
            req_last[IW'(n)]  = pres[n] ? lq[n][0] : 1'b0;
        end
        fifo_full = (fq_cnt >= depth);
        rst_i     = rst_cur;
        #1;

        eg = '0;
        er = '0;
        ew = 1'b0;
        if (m_busy != 0) eg[IW'(m_g)] = 1'b1;
        if (m_busy != 0 && !rst_cur) begin
            er[IW'(m_g)] = !fifo_full;
            ew = req_valid[IW'(m_g)] && !fifo_full;
        end
        if (armed) begin
            chk("grant", 32'(grant), 32'(eg));
            chk("busy", 32'(busy), 32'(m_busy != 0));
            chk("ready", 32'(req_ready), 32'(er));
            chk("wr", 32'(fifo_wr), 32'(ew));
            if (ew) chk("wdata", 32'(fifo_wdata), 32'(dq[m_g][0]));
            else if (m_busy == 0) chk("idle_wdata", 32'(fifo_wdata), 32'(0));
        end

        do_pop = (fq_cnt > 0) && (int'($urandom_range(99, 0)) < p_pop);
        if (do_pop) fq_cnt--;
        if (ew) begin
            fq_cnt++;
            n_writes++;
        end

        if (rst_cur) begin
            m_busy  = 0;
            m_beats = 0;
            m_ptr   = NR - 1;
        end else if (m_busy == 0) begin
            found = 1'b0;
            for (int k = 1; k <= NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (!found && req_valid[IW'(idx)]) begin
                    found   = 1'b1;
                    m_busy  = 1;
                    m_g     = idx;
                    m_beats = 0;
                end
            end
        end else if (ew) begin
            acc[m_g] = 1'b1;
            m_beats++;
            if (lq[m_g][0] || m_beats == MB) begin
                m_busy = 0;
                m_ptr  = m_g;
            end
        end
    endtask

    task automatic run(int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic do_reset(int cycles);
        rst_cur = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            step();
            armed = 1'b1;
        end
        rst_cur = 1'b0;
    endtask

    initial begin
        int w0;
        rst_i     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        armed     = 1'b0;
        m_busy = 0; m_g = 0; m_beats = 0; m_ptr = NR - 1;
        depth = 64; p_pop = 100; p_pres = 100; maxlen = 1;
        autogen = 1'b0; mask = '0; rst_cur = 1'b1;

        // Single producer, three-word packet.
        clear_all();
        do_reset(2);
        push_word(0, 8'h11, 1'b0);
        push_word(0, 8'h22, 1'b0);
        push_word(0, 8'h33, 1'b1);
        mask = 4'b0001;
        w0 = n_writes;
        run(8);
        chk("single_words", 32'(n_writes - w0), 32'(3));

        // Fairness with single-word packets: one write every two cycles.
        clear_all();
        autogen = 1'b1; maxlen = 1; mask = 4'b1111;
        do_reset(2);
        w0 = n_writes;
        run(24);
        chk("fair_rate", 32'(n_writes - w0), 32'(12));

        // Burst limit: producer 2 long packet interleaved with producer 3.
        autogen = 1'b0;
        clear_all();
        do_reset(2);
        for (int k = 0; k < 10; k++) push_word(2, W'(8'h20 + k), k == 9);
        push_word(3, 8'hA0, 1'b0);
        push_word(3, 8'hA1, 1'b1);
        mask = 4'b1100;
        w0 = n_writes;
        run(30);
        chk("burst_words", 32'(n_writes - w0), 32'(12));

        // Reset on beat 2 of a five-word packet; producer 0 must win again.
        clear_all();
        do_reset(2);
        for (int k = 0; k < 5; k++) push_word(0, W'(8'h50 + k), k == 4);
        push_word(1, 8'h60, 1'b0);
        push_word(1, 8'h61, 1'b1);
        mask = 4'b0011;
        w0 = n_writes;
        run(2);
        rst_cur = 1'b1;
        step();
        rst_cur = 1'b0;
        run(12);
        chk("reset_words", 32'(n_writes - w0), 32'(7));

        // Random traffic with valid gaps, FIFO back-pressure and occasional resets.
        clear_all();
        autogen = 1'b1; maxlen = 7; mask = 4'b1111;
        p_pres = 60; depth = 3; p_pop = 40;
        do_reset(2);
        for (int i = 0; i < 600; i++) begin
            rst_cur = ($urandom_range(199, 0) == 0);
            step();
        end
        rst_cur = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
